// File: rtl/jtdd_mcu_com.sv
// -----------------------------------------------------------------------------
// jtdd_mcu_com
//
// MCU-side counterpart of the main CPU's MCU interface. It sits between
// jtdd_main and the HD63701 MCU core and provides:
//   * the shared communication RAM (true dual port, synchronous read-first)
//   * the NMI latch set by the main CPU and cleared by the MCU
//   * the halt / bus-release handshake that drives mcu_ban
//   * the mcu_irqmain pulse generator back to the main CPU
//
// Parameters
//   AW       shared RAM address width, depth is 2**AW bytes
//   IRQ_LEN  mcu_irqmain pulse width in cen_main ticks (1..15)
//
// Ports
//   clk, rstn                        clock, synchronous active-low reset
//   cen_main, cen_mcu                clock enables of main CPU and MCU
//   main_addr/main_dout/main_rnw     main CPU bus, com_cs selects the RAM
//   mcu_nmi_set, mcu_halt            main CPU NMI strobe and halt level
//   mcu_ram                          RAM read data towards the main CPU
//   mcu_irqmain                      IRQ pulse towards the main CPU
//   mcu_ban                          MCU halted and its bus released
//   mcu_addr/mcu_wdata/mcu_we/mcu_cs MCU bus into the shared RAM
//   mcu_rdata                        RAM read data towards the MCU
//   mcu_nmi_ack, mcu_irq_wr          MCU strobes: clear NMI, request IRQ
//   mcu_idle                         MCU at an instruction boundary
//   mcu_nmin, mcu_haltreq            NMI (active low) and halt request to MCU
// -----------------------------------------------------------------------------
module jtdd_mcu_com #(
    parameter int AW      = 9,
    parameter int IRQ_LEN = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cen_main,
    input  logic          cen_mcu,
    // main CPU side
    input  logic [AW-1:0] main_addr,
    input  logic [7:0]    main_dout,
    input  logic          main_rnw,
    input  logic          com_cs,
    input  logic          mcu_nmi_set,
    input  logic          mcu_halt,
    output logic [7:0]    mcu_ram,
    output logic          mcu_irqmain,
    output logic          mcu_ban,
    // MCU side
    input  logic [AW-1:0] mcu_addr,
    input  logic [7:0]    mcu_wdata,
    input  logic          mcu_we,
    input  logic          mcu_cs,
    output logic [7:0]    mcu_rdata,
    input  logic          mcu_nmi_ack,
    input  logic          mcu_irq_wr,
    input  logic          mcu_idle,
    output logic          mcu_nmin,
    output logic          mcu_haltreq
);

    localparam logic [3:0] IRQ_LEN_C = 4'(IRQ_LEN);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        REQ    = 2'd1,
        HALTED = 2'd2,
        RESUME = 2'd3
    } halt_state_t;

    typedef enum logic [1:0] {
        IRQ_IDLE  = 2'd0,
        IRQ_PULSE = 2'd1,
        IRQ_GAP   = 2'd2
    } irq_state_t;

    halt_state_t halt_state, halt_nxt;
    irq_state_t  irq_state,  irq_nxt;
    logic [3:0]  irq_cnt,    irq_cnt_nxt;
    logic        irq_pend,   irq_pend_nxt;
    logic        nmi_pend;

    // -------------------------------------------------------------------------
    // Shared RAM
    // -------------------------------------------------------------------------
    logic [7:0] mem [0:(2**AW)-1];

    logic main_wr_en;
    logic mcu_wr_en;
    logic mcu_wr_keep;

    assign main_wr_en  = com_cs & ~main_rnw & cen_main;
    // The MCU cannot touch the RAM while its bus is released.
    assign mcu_wr_en   = mcu_cs & mcu_we & cen_mcu & (halt_state != HALTED);
    // On a same-address collision the main CPU owns the byte.
    assign mcu_wr_keep = mcu_wr_en & ~(main_wr_en && (main_addr == mcu_addr));

    // NOTE: the RAM array has no reset so it maps onto block RAM and keeps its
    // contents across a reset; only the read data registers are cleared.
    always_ff @(posedge clk) begin
        if (mcu_wr_keep) mem[mcu_addr]  <= mcu_wdata;
        if (main_wr_en)  mem[main_addr] <= main_dout;
    end

    // Read-first: the array update above is non-blocking, so a read of an
    // address written on the same edge returns the previous contents.
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // sample their inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mcu_ram   <= 8'd0;
            mcu_rdata <= 8'd0;
        end else begin
            mcu_ram   <= mem[main_addr];
            mcu_rdata <= mem[mcu_addr];
        end
    end

    // -------------------------------------------------------------------------
    // NMI latch: a set in the same clk as an ack takes priority.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            nmi_pend <= 1'b0;
        end else if (cen_main && mcu_nmi_set) begin
            nmi_pend <= 1'b1;
        end else if (cen_mcu && mcu_nmi_ack) begin
            nmi_pend <= 1'b0;
        end
    end

    assign mcu_nmin = ~nmi_pend;

    // -------------------------------------------------------------------------
    // Halt / bus-release handshake
    // -------------------------------------------------------------------------
    // NOTE: the next-state value is defaulted to the current state before the
    // case statement so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        halt_nxt = halt_state;
        case (halt_state)
            RUN:    if (mcu_halt) halt_nxt = REQ;
            // Withdrawing the halt request wins over a coincident idle.
            REQ:    if (!mcu_halt)                 halt_nxt = RUN;
                    else if (cen_mcu && mcu_idle)  halt_nxt = HALTED;
            HALTED: if (!mcu_halt) halt_nxt = RESUME;
            RESUME: if (cen_mcu)   halt_nxt = RUN;
            default: halt_nxt = RUN;
        endcase
    end

    // Outputs are decoded from the next state and registered so that mcu_ban
    // changes on exactly the clk that enters or leaves HALTED.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            halt_state  <= RUN;
            mcu_haltreq <= 1'b0;
            mcu_ban     <= 1'b0;
        end else begin
            halt_state  <= halt_nxt;
            mcu_haltreq <= (halt_nxt == REQ) || (halt_nxt == HALTED);
            mcu_ban     <= (halt_nxt == HALTED);
        end
    end

    // -------------------------------------------------------------------------
    // IRQ pulse to the main CPU
    //   IDLE  : a request starts a pulse of IRQ_LEN cen_main ticks
    //   PULSE : counts cen_main ticks down; requests set a one-deep pending
    //   GAP   : one low cen_main tick so main always sees a fresh rising edge;
    //           a pending (or coincident) request then restarts the pulse
    // -------------------------------------------------------------------------
    logic irq_req;
    assign irq_req = cen_mcu & mcu_irq_wr;

    always_comb begin
        irq_nxt      = irq_state;
        irq_cnt_nxt  = irq_cnt;
        irq_pend_nxt = irq_pend;
        case (irq_state)
            IRQ_IDLE: begin
                if (irq_req) begin
                    irq_nxt     = IRQ_PULSE;
                    irq_cnt_nxt = IRQ_LEN_C;
                end
            end
            IRQ_PULSE: begin
                if (cen_main) begin
                    irq_cnt_nxt = irq_cnt - 4'd1;
                    if (irq_cnt == 4'd1) irq_nxt = IRQ_GAP;
                end
                if (irq_req) irq_pend_nxt = 1'b1;
            end
            IRQ_GAP: begin
                if (cen_main) begin
                    if (irq_pend || irq_req) begin
                        irq_nxt      = IRQ_PULSE;
                        irq_cnt_nxt  = IRQ_LEN_C;
                        irq_pend_nxt = 1'b0;
                    end else begin
                        irq_nxt = IRQ_IDLE;
                    end
                end else if (irq_req) begin
                    irq_pend_nxt = 1'b1;
                end
            end
            default: begin
                irq_nxt      = IRQ_IDLE;
                irq_cnt_nxt  = 4'd0;
                irq_pend_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            irq_state   <= IRQ_IDLE;
            irq_cnt     <= 4'd0;
            irq_pend    <= 1'b0;
            mcu_irqmain <= 1'b0;
        end else begin
            irq_state   <= irq_nxt;
            irq_cnt     <= irq_cnt_nxt;
            irq_pend    <= irq_pend_nxt;
            mcu_irqmain <= (irq_nxt == IRQ_PULSE);
        end
    end

endmodule

// File: tb/tb_jtdd_mcu_com.sv
// -----------------------------------------------------------------------------
// tb_jtdd_mcu_com
//
// Directed scenarios followed by randomized traffic. A behavioural model of the
// communication block is advanced on every clock edge and all outputs are
// compared against it once checking is enabled.
// -----------------------------------------------------------------------------
module tb_jtdd_mcu_com;

    localparam int AW      = 9;
    localparam int IRQ_LEN = 4;
    localparam int DEPTH   = 2 ** AW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cen_main, cen_mcu;
    logic [AW-1:0] main_addr;
    logic [7:0]    main_dout;
    logic          main_rnw, com_cs, mcu_nmi_set, mcu_halt;
    logic [7:0]    mcu_ram;
    logic          mcu_irqmain, mcu_ban;
    logic [AW-1:0] mcu_addr;
    logic [7:0]    mcu_wdata;
    logic          mcu_we, mcu_cs;
    logic [7:0]    mcu_rdata;
    logic          mcu_nmi_ack, mcu_irq_wr, mcu_idle;
    logic          mcu_nmin, mcu_haltreq;

    jtdd_mcu_com #(.AW(AW), .IRQ_LEN(IRQ_LEN)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cen_main   (cen_main),
        .cen_mcu    (cen_mcu),
        .main_addr  (main_addr),
        .main_dout  (main_dout),
        .main_rnw   (main_rnw),
        .com_cs     (com_cs),
        .mcu_nmi_set(mcu_nmi_set),
        .mcu_halt   (mcu_halt),
        .mcu_ram    (mcu_ram),
        .mcu_irqmain(mcu_irqmain),
        .mcu_ban    (mcu_ban),
        .mcu_addr   (mcu_addr),
        .mcu_wdata  (mcu_wdata),
        .mcu_we     (mcu_we),
        .mcu_cs     (mcu_cs),
        .mcu_rdata  (mcu_rdata),
        .mcu_nmi_ack(mcu_nmi_ack),
        .mcu_irq_wr (mcu_irq_wr),
        .mcu_idle   (mcu_idle),
        .mcu_nmin   (mcu_nmin),
        .mcu_haltreq(mcu_haltreq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit auto_chk = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    logic [7:0] mm [DEPTH];
    logic [7:0] m_ram, m_rdata;
    bit         m_nmi;                 // NMI requested and not yet acknowledged
    bit         m_want, m_released, m_resuming;
    bit         m_irq, m_gap, m_pend;
    int         m_left;

    function automatic void model_step();
        bit req;
        if (!rstn) begin
            m_ram = 8'h00; m_rdata = 8'h00;
            m_nmi = 0;
            m_want = 0; m_released = 0; m_resuming = 0;
            m_irq = 0; m_gap = 0; m_pend = 0; m_left = 0;
            return;
        end
        // RAM: reads see the contents from before this edge; main wins a tie.
        m_ram   = mm[int'(main_addr)];
        m_rdata = mm[int'(mcu_addr)];
        if (mcu_cs && mcu_we && cen_mcu && !m_released) mm[int'(mcu_addr)] = mcu_wdata;
        if (com_cs && !main_rnw && cen_main)             mm[int'(main_addr)] = main_dout;

        if (cen_main && mcu_nmi_set)     m_nmi = 1;
        else if (cen_mcu && mcu_nmi_ack) m_nmi = 0;

        // Halt handshake, described as "requesting / released / resuming".
        if (m_resuming) begin
            if (cen_mcu) m_resuming = 0;
        end else if (m_released) begin
            if (!mcu_halt) begin m_released = 0; m_want = 0; m_resuming = 1; end
        end else if (m_want) begin
            if (!mcu_halt)                m_want = 0;
            else if (cen_mcu && mcu_idle) m_released = 1;
        end else if (mcu_halt) begin
            m_want = 1;
        end

        // IRQ pulse: length counted in cen_main ticks, one low tick between pulses.
        req = cen_mcu && mcu_irq_wr;
        if (m_irq) begin
            if (cen_main) begin
                m_left = m_left - 1;
                if (m_left == 0) begin m_irq = 0; m_gap = 1; end
            end
            if (req) m_pend = 1;
        end else if (m_gap) begin
            if (cen_main) begin
                m_gap = 0;
                if (m_pend || req) begin m_irq = 1; m_left = IRQ_LEN; m_pend = 0; end
            end else if (req) begin
                m_pend = 1;
            end
        end else if (req) begin
            m_irq = 1; m_left = IRQ_LEN;
        end
    endfunction

    task automatic compare_all();
        check("ram",     16'(mcu_ram),     16'(m_ram));
        check("rdata",   16'(mcu_rdata),   16'(m_rdata));
        check("nmin",    16'(mcu_nmin),    16'(!m_nmi));
        check("haltreq", 16'(mcu_haltreq), 16'(m_want));
        check("ban",     16'(mcu_ban),     16'(m_released));
        check("irq",     16'(mcu_irqmain), 16'(m_irq));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (auto_chk) compare_all();
    endtask

    task automatic idle_inputs();
        cen_main = 0; cen_mcu = 0;
        com_cs = 0; main_rnw = 1; main_dout = 8'h00; main_addr = '0;
        mcu_cs = 0; mcu_we = 0; mcu_wdata = 8'h00; mcu_addr = '0;
        mcu_nmi_set = 0; mcu_nmi_ack = 0; mcu_irq_wr = 0;
        mcu_halt = 0; mcu_idle = 0;
    endtask

    // Drive mcu_irq_wr at chosen clocks with cen_main every 4th clk and
    // record mcu_irqmain as seen by main on each cen_main tick.
    task automatic irq_window(input int n_clk, input int r0, input int r1,
                              input int r2, input int r3,
                              output int highs, output int rises, output int gap);
        bit q[$];
        bit prev_s;
        int i0;
        for (int k = 0; k < n_clk; k++) begin
            cen_main   = (k % 4 == 3);
            mcu_irq_wr = (k == r0) || (k == r1) || (k == r2) || (k == r3);
            cen_mcu    = mcu_irq_wr;
            if (cen_main) q.push_back(mcu_irqmain);
            tick();
        end
        cen_main = 0; cen_mcu = 0; mcu_irq_wr = 0;
        highs = 0; rises = 0; gap = 0; prev_s = 0;
        foreach (q[i]) begin
            if (q[i]) highs++;
            if (q[i] && !prev_s) rises++;
            prev_s = q[i];
        end
        i0 = 0;
        while (i0 < q.size() && !q[i0]) i0++;
        while (i0 < q.size() && q[i0])  i0++;
        while (i0 < q.size() && !q[i0]) begin gap++; i0++; end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int highs, rises, gap, rst_hold;

        idle_inputs();
        rstn = 0;
        tick(); tick();
        check("rst_nmin",    16'(mcu_nmin),    16'h1);
        check("rst_haltreq", 16'(mcu_haltreq), 16'h0);
        check("rst_ban",     16'(mcu_ban),     16'h0);
        check("rst_irq",     16'(mcu_irqmain), 16'h0);
        check("rst_ram",     16'(mcu_ram),     16'h0);
        check("rst_rdata",   16'(mcu_rdata),   16'h0);
        rstn = 1;

        // Give every RAM byte a known value through the main port.
        for (int a = 0; a < DEPTH; a++) begin
            com_cs = 1; main_rnw = 0; cen_main = 1;
            main_addr = AW'(a); main_dout = 8'(a) ^ 8'hA5;
            tick();
        end
        idle_inputs();
        tick();
        auto_chk = 1;

        // Main write then MCU read.
        com_cs = 1; main_rnw = 0; cen_main = 1; main_addr = 9'h010; main_dout = 8'h5A;
        tick();
        idle_inputs();
        mcu_addr = 9'h010;
        tick();
        check("mcu_read_5a", 16'(mcu_rdata), 16'h005A);

        // Same-address collision: main data is kept.
        com_cs = 1; main_rnw = 0; cen_main = 1; main_addr = 9'h1FF; main_dout = 8'h11;
        mcu_cs = 1; mcu_we = 1; cen_mcu = 1; mcu_addr = 9'h1FF; mcu_wdata = 8'h22;
        tick();
        idle_inputs();
        main_addr = 9'h1FF; mcu_addr = 9'h1FF;
        tick();
        check("coll_main", 16'(mcu_ram),   16'h0011);
        check("coll_mcu",  16'(mcu_rdata), 16'h0011);

        // NMI latch.
        mcu_nmi_set = 1; cen_main = 1;
        tick();
        mcu_nmi_set = 0; cen_main = 0;
        tick(); tick(); tick();
        check("nmi_held", 16'(mcu_nmin), 16'h0);
        mcu_nmi_ack = 1; cen_mcu = 1;
        tick();
        mcu_nmi_ack = 0; cen_mcu = 0;
        check("nmi_ack", 16'(mcu_nmin), 16'h1);
        mcu_nmi_set = 1; cen_main = 1; mcu_nmi_ack = 1; cen_mcu = 1;
        tick();
        check("nmi_set_wins", 16'(mcu_nmin), 16'h0);
        mcu_nmi_set = 0; cen_main = 0;
        tick();
        mcu_nmi_ack = 0; cen_mcu = 0;
        check("nmi_clear", 16'(mcu_nmin), 16'h1);

        // Halt handshake.
        mcu_halt = 1; mcu_idle = 0; cen_mcu = 1;
        tick(); tick();
        check("req_haltreq", 16'(mcu_haltreq), 16'h1);
        check("req_ban",     16'(mcu_ban),     16'h0);
        mcu_idle = 1;
        tick();
        check("halted_ban", 16'(mcu_ban), 16'h1);
        mcu_cs = 1; mcu_we = 1; mcu_addr = 9'h020; mcu_wdata = 8'h77;
        tick();
        mcu_cs = 0; mcu_we = 0; cen_mcu = 0;
        tick(); tick();
        check("halted_wr_blocked", 16'(mcu_rdata), 16'h0085);
        mcu_halt = 0;
        tick();
        check("resume_ban",     16'(mcu_ban),     16'h0);
        check("resume_haltreq", 16'(mcu_haltreq), 16'h0);
        tick(); tick();
        cen_mcu = 1;
        tick();
        cen_mcu = 0;
        mcu_halt = 1;        // back in RUN, so this is seen at once
        tick();
        check("run_again", 16'(mcu_haltreq), 16'h1);
        mcu_halt = 0; mcu_idle = 0;
        tick(); tick();

        // IRQ pulses with cen_main every 4 clk.
        irq_window(40, 0, -1, -1, -1, highs, rises, gap);
        check("irq_single_high", 16'(highs), 16'd4);
        check("irq_single_rise", 16'(rises), 16'd1);
        irq_window(64, 0, 2, 5, 9, highs, rises, gap);
        check("irq_double_high", 16'(highs), 16'd8);
        check("irq_double_rise", 16'(rises), 16'd2);
        check("irq_gap",         16'(gap),   16'd1);

        // Reset while halted with a pulse active.
        mcu_halt = 1; mcu_idle = 1; cen_mcu = 1;
        tick(); tick();
        mcu_irq_wr = 1;
        tick();
        mcu_irq_wr = 0; cen_mcu = 0;
        check("pre_rst_ban", 16'(mcu_ban),     16'h1);
        check("pre_rst_irq", 16'(mcu_irqmain), 16'h1);
        rstn = 0;
        tick();
        check("mid_rst_ban",     16'(mcu_ban),     16'h0);
        check("mid_rst_irq",     16'(mcu_irqmain), 16'h0);
        check("mid_rst_haltreq", 16'(mcu_haltreq), 16'h0);
        mcu_halt = 0; mcu_idle = 0;
        main_addr = 9'h010; mcu_addr = 9'h1FF;
        rstn = 1;
        tick(); tick();
        check("keep_ram_010", 16'(mcu_ram),   16'h005A);
        check("keep_ram_1ff", 16'(mcu_rdata), 16'h0011);

        // Randomized traffic against the model.
        rst_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (rst_hold > 0) begin
                rst_hold--;
                rstn = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_hold = int'($urandom_range(0, 2));
                rstn = 0;
            end else begin
                rstn = 1;
            end
            cen_main    = ($urandom_range(0, 2) == 0);
            cen_mcu     = ($urandom_range(0, 1) == 0);
            main_addr   = AW'($urandom_range(0, DEPTH - 1));
            mcu_addr    = ($urandom_range(0, 3) == 0) ? main_addr : AW'($urandom_range(0, DEPTH - 1));
            main_dout   = 8'($urandom);
            mcu_wdata   = 8'($urandom);
            main_rnw    = ($urandom_range(0, 1) == 0);
            com_cs      = rstn && ($urandom_range(0, 1) == 0);
            mcu_cs      = rstn && ($urandom_range(0, 1) == 0);
            mcu_we      = ($urandom_range(0, 1) == 0);
            mcu_nmi_set = ($urandom_range(0, 15) == 0);
            mcu_nmi_ack = ($urandom_range(0, 7) == 0);
            mcu_irq_wr  = ($urandom_range(0, 9) == 0);
            mcu_idle    = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) mcu_halt = ~mcu_halt;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jtdd_mcu_com.md
Name: jtdd_mcu_com

Overview:
- MCU-side counterpart of the main CPU's MCU interface.
- Holds the shared communication RAM (main side selected by com_cs).
- Latches the main CPU's MCU NMI strobe until the MCU acknowledges it.
- Runs the halt/bus-release handshake, which drives mcu_ban, and generates the mcu_irqmain pulse back to the main CPU.
- Sits between jtdd_main and the HD63701 MCU core in the game top level.

Parameters:
- AW, 9: shared RAM address width; depth is 2^AW bytes.
- IRQ_LEN, 4: width of the mcu_irqmain pulse, counted in cen_main ticks (1..15).

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous, active-low reset
- cen_main  in  1  main CPU clock enable (cpu_cen from main)
- cen_mcu  in  1  MCU clock enable
- main_addr  in  AW  main CPU address, low bits
- main_dout  in  8  main CPU write data
- main_rnw  in  1  main CPU read/not-write
- com_cs  in  1  main CPU selects shared RAM
- mcu_nmi_set  in  1  main CPU strobe requesting MCU NMI
- mcu_halt  in  1  main CPU level requesting MCU halt
- mcu_ram  out  8  shared RAM read data to main
- mcu_irqmain  out  1  IRQ pulse to main CPU
- mcu_ban  out  1  high while MCU is halted and its bus is released
- mcu_addr  in  AW  MCU address into shared RAM
- mcu_wdata  in  8  MCU write data
- mcu_we  in  1  MCU write strobe
- mcu_cs  in  1  MCU selects shared RAM
- mcu_rdata  out  8  shared RAM read data to MCU
- mcu_nmi_ack  in  1  MCU write strobe that clears the pending NMI
- mcu_irq_wr  in  1  MCU write strobe that requests an IRQ to main
- mcu_idle  in  1  MCU is at an instruction boundary and can release its bus
- mcu_nmin  out  1  NMI to MCU, active low
- mcu_haltreq  out  1  halt request to MCU core

Behaviour:
- All state changes occur on posedge clk.
- When rstn=0: mcu_nmin=1, mcu_haltreq=0, mcu_ban=0, mcu_irqmain=0, mcu_ram=0, mcu_rdata=0, FSM goes to RUN, counters and the pending flag clear. RAM contents are not cleared.
- Reset asserted mid-handshake or mid-pulse aborts it immediately.

Shared RAM:
- True dual port with synchronous read.
- Read data appears 1 clk after address. Reads are read-first: a read at an address written in the same cycle returns the old data.
- Main port writes when com_cs & ~main_rnw & cen_main.
- MCU port writes when mcu_cs & mcu_we & cen_mcu, and state != HALTED.
- Both ports writing the same address in the same clk: main data is stored and the MCU write is dropped.

NMI latch:
- nmi_pend sets on cen_main & mcu_nmi_set.
- nmi_pend clears on cen_mcu & mcu_nmi_ack.
- Set and clear in the same clk: set wins.
- mcu_nmin = ~nmi_pend, registered.

Halt FSM (states RUN, REQ, HALTED, RESUME):
- RUN: mcu_haltreq=0. Go to REQ when mcu_halt=1.
- REQ: mcu_haltreq=1. Go to HALTED on cen_mcu & mcu_idle. If mcu_halt drops first, go back to RUN.
- HALTED: mcu_haltreq=1, mcu_ban=1. Go to RESUME when mcu_halt=0.
- RESUME: mcu_haltreq=0, mcu_ban=0. Go to RUN on the next cen_mcu.
- mcu_ban is registered. It rises on the clk that enters HALTED and falls on the clk that leaves it.

IRQ to main:
- A request is cen_mcu & mcu_irq_wr.
- When idle, a request sets mcu_irqmain=1 and loads the counter with IRQ_LEN.
- The counter decrements on each cen_main. mcu_irqmain falls when it reaches 0.
- A request arriving while the pulse is high sets a one-deep pending flag; further requests are dropped.
- After the pulse ends, mcu_irqmain stays low for exactly one cen_main tick. The pending request then starts a new pulse, so main always sees a fresh rising edge.

Test Plan:
- Reset release: all outputs match reset values. Write 0x5A at main address 0x010, then read it on the MCU port: mcu_rdata=0x5A one clk after the address is applied.
- Write collision: main writes 0x11 and MCU writes 0x22 to address 0x1FF in the same clk. A following read on both ports returns 0x11.
- NMI: one cen_main pulse of mcu_nmi_set drives mcu_nmin=0 and holds it. mcu_nmi_ack on cen_mcu returns mcu_nmin to 1. Set and ack together leave mcu_nmin=0.
- Halt handshake: raise mcu_halt with mcu_idle=0; mcu_haltreq=1 and mcu_ban=0. Raise mcu_idle; mcu_ban=1. An MCU write to 0x020 is ignored. Drop mcu_halt; mcu_ban falls, then the FSM reaches RUN after one cen_mcu.
- IRQ pulse with IRQ_LEN=4 and cen_main every 4 clk: one mcu_irq_wr gives mcu_irqmain high for 4 cen_main ticks. Three requests during the pulse give exactly one extra pulse, separated by one low cen_main tick.
- Reset mid-operation: pull rstn low while in HALTED with a pulse active. On the next clk, mcu_ban=0, mcu_irqmain=0, the FSM is in RUN and RAM contents are preserved.
